// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: UART transmitter, one CLK cycle per line bit.
// Frame: start (0), data LSB first, optional parity, stop (1).
// Parity support is built only when the macro UART_TX_PARITY_EN is defined;
// otherwise PAR_EN/PAR_TYP are ignored and every frame is width+2 bits.
module uart_tx_fsm #(
  parameter int width = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [width-1:0] P_DATA,
  input  logic             Data_valid,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic             TX_OUT,
  output logic             Busy
);

  // state     | meaning
  // S_IDLE    | line high, not busy, waiting for Data_valid
  // S_START   | start bit (0) on the line
  // S_DATA    | data bit cnt_q on the line, LSB first
  // S_PARITY  | latched parity bit on the line (parity build only)
  // S_STOP    | stop bit (1) on the line; a new word may be accepted here

  localparam int CNT_W = (width > 1) ? $clog2(width) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(width - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [width-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             accept;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
`else
  logic unused_par_inputs;
  assign unused_par_inputs = PAR_EN ^ PAR_TYP;
`endif

  // Next-state, next line value and datapath updates; line and Busy are
  // computed one cycle ahead so both come straight out of flops.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    accept = Data_valid && ((state_q == S_IDLE) || (state_q == S_STOP));

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      S_START: begin
        state_d = S_DATA;
        tx_d    = shreg_q[0];
        shreg_d = shreg_q >> 1;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
      S_DATA: begin
        busy_d = 1'b1;
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          if (par_en_q) begin
            state_d = S_PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end
`else
          state_d = S_STOP;
          tx_d    = 1'b1;
`endif
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        state_d = S_STOP;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
      end
`endif
      S_STOP: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Acceptance overrides the stop-bit exit, giving back-to-back frames.
    if (accept) begin
      state_d = S_START;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      shreg_d = P_DATA;
`ifdef UART_TX_PARITY_EN
      par_en_d  = PAR_EN;
      par_bit_d = (^P_DATA) ^ PAR_TYP;
`endif
    end
  end

  // State, datapath and output registers; reset forces the line high at once.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule
